// File: rtl/bsg_rocc_mem_responder_if.sv
// RoCC memory-port request/response types and the handshake bundle between
// a requester (master) and the Rocket-side memory responder (slave).
package bsg_rocc_mem_pkg;

  localparam int rocc_addr_width_gp = 40;
  localparam int rocc_tag_width_gp  = 10;
  localparam int rocc_data_width_gp = 64;

  typedef enum logic [4:0] {
    eRoCC_mem_load  = 5'h00,
    eRoCC_mem_store = 5'h01
  } bsg_rocc_mem_cmd_e;

  typedef enum logic [2:0] {
    eRoCC_mem_32bits = 3'b010,
    eRoCC_mem_64bits = 3'b011
  } bsg_rocc_mem_typ_e;

  typedef struct packed {
    logic [rocc_addr_width_gp-1:0] req_addr;
    logic [rocc_tag_width_gp-1:0]  req_tag;
    logic [4:0]                    req_cmd;
    logic [2:0]                    req_typ;
    logic                          req_phys;
    logic [rocc_data_width_gp-1:0] req_data;
  } rocc_mem_req_s;

  typedef struct packed {
    logic [rocc_addr_width_gp-1:0] resp_addr;
    logic [rocc_tag_width_gp-1:0]  resp_tag;
    logic [4:0]                    resp_cmd;
    logic [2:0]                    resp_typ;
    logic [rocc_data_width_gp-1:0] resp_data;
    logic                          resp_has_data;
  } rocc_mem_resp_s;

endpackage

interface bsg_rocc_mem_responder_if;
  import bsg_rocc_mem_pkg::*;

  logic           mem_req_valid_i;
  rocc_mem_req_s  mem_req_s_i;
  logic           mem_req_ready_o;
  logic           mem_resp_valid_o;
  rocc_mem_resp_s mem_resp_s_o;

  modport master (
    output mem_req_valid_i, mem_req_s_i,
    input  mem_req_ready_o, mem_resp_valid_o, mem_resp_s_o
  );

  modport slave (
    input  mem_req_valid_i, mem_req_s_i,
    output mem_req_ready_o, mem_resp_valid_o, mem_resp_s_o
  );
endinterface

// File: rtl/bsg_rocc_mem_responder.sv
// Rocket-side RoCC memory responder: a word-addressed array that answers every
// accepted load/store with exactly one response lat_p cycles later.
// Optional request throttling: define BSG_ROCC_MEM_RESPONDER_STALL_EN.
module bsg_rocc_mem_responder
  import bsg_rocc_mem_pkg::*;
#(
  parameter int els_p = 256,
  parameter int lat_p = 2
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  bsg_rocc_mem_responder_if.slave      mem_if,
  output logic [$clog2(lat_p+1)-1:0]   pending_o,
  output logic                         err_r_o
);

  localparam int lg_els_lp = $clog2(els_p);
  localparam int pend_w_lp = $clog2(lat_p+1);

  rocc_mem_req_s        req;
  logic                 accept;
  logic [lg_els_lp-1:0] idx;
  logic                 in_range, is_load, is_store, is32, is64, aligned, err_req;
  logic [63:0]          rd_word, load_data;
  rocc_mem_resp_s       resp_next;
  logic                 ready_en_r;
  logic [63:0]          mem_r [els_p];
  logic [lat_p-1:0]     valid_r;
  rocc_mem_resp_s       resp_r [lat_p];
  logic [pend_w_lp-1:0] pending_r;
  logic                 err_r;
  logic                 unused_phys;

  assign req         = mem_if.mem_req_s_i;
  assign accept      = mem_if.mem_req_valid_i & mem_if.mem_req_ready_o;
  assign idx         = req.req_addr[3 +: lg_els_lp];
  assign unused_phys = req.req_phys;

  assign in_range = (req.req_addr >> 3) < rocc_addr_width_gp'(els_p);
  assign is_load  = (req.req_cmd == eRoCC_mem_load);
  assign is_store = (req.req_cmd == eRoCC_mem_store);
  assign is32     = (req.req_typ == eRoCC_mem_32bits);
  assign is64     = (req.req_typ == eRoCC_mem_64bits);
  assign aligned  = is64 ? (req.req_addr[2:0] == 3'b000)
                  : is32 ? (req.req_addr[1:0] == 2'b00)
                  : 1'b0;
  assign err_req  = ~in_range | ~(is_load | is_store) | ~aligned;

  // Asynchronous array read; the only write of a cycle lands at its end edge.
  assign rd_word   = mem_r[idx];
  assign load_data = is64 ? rd_word
                   : {32'h0, (req.req_addr[2] ? rd_word[63:32] : rd_word[31:0])};

  // Build the response for the request being presented this cycle.
  always_comb begin
    resp_next               = '0;
    resp_next.resp_addr     = req.req_addr;
    resp_next.resp_tag      = req.req_tag;
    resp_next.resp_cmd      = req.req_cmd;
    resp_next.resp_typ      = req.req_typ;
    resp_next.resp_has_data = is_load;
    if (is_load & ~err_req) resp_next.resp_data = load_data;
  end

  // Store path: erroneous stores are dropped; 32-bit stores touch one half only.
  always_ff @(posedge clk_i) begin
    if (accept & is_store & ~err_req) begin
      if (is64)                mem_r[idx]        <= req.req_data;
      else if (req.req_addr[2]) mem_r[idx][63:32] <= req.req_data[31:0];
      else                     mem_r[idx][31:0]  <= req.req_data[31:0];
    end
  end

  // Fixed-latency valid/payload shift pipeline; reset discards in-flight entries.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      valid_r <= '0;
      for (int unsigned i = 0; i < lat_p; i++) resp_r[i] <= '0;
    end else begin
      valid_r[0] <= accept;
      resp_r[0]  <= accept ? resp_next : '0;
      for (int unsigned i = 1; i < lat_p; i++) begin
        valid_r[i] <= valid_r[i-1];
        resp_r[i]  <= resp_r[i-1];
      end
    end
  end

  assign mem_if.mem_resp_valid_o = valid_r[lat_p-1];
  assign mem_if.mem_resp_s_o     = resp_r[lat_p-1];

  // In-flight count: up on accept, down on response, unchanged when both.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) pending_r <= '0;
    else begin
      case ({accept, mem_if.mem_resp_valid_o})
        2'b10:   pending_r <= pending_r + pend_w_lp'(1);
        2'b01:   pending_r <= pending_r - pend_w_lp'(1);
        default: pending_r <= pending_r;
      endcase
    end
  end

  assign pending_o = pending_r;

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i)           err_r <= 1'b0;
    else if (accept & err_req) err_r <= 1'b1;
  end

  assign err_r_o = err_r;

  // Ready is registered so it never depends on the incoming valid.
  always_ff @(posedge clk_i) begin
    ready_en_r <= reset_n_i;
  end

`ifdef BSG_ROCC_MEM_RESPONDER_STALL_EN
  logic [7:0] lfsr_r;

  // Free-running throttle pattern (taps 8,6,5,4), advances every cycle out of reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) lfsr_r <= 8'h01;
    else            lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
  end

  assign mem_if.mem_req_ready_o = ready_en_r & ~(lfsr_r[1] & lfsr_r[0]);
`else
  assign mem_if.mem_req_ready_o = ready_en_r;
`endif

endmodule

// File: tb/tb_bsg_rocc_mem_responder.sv
// Randomized and directed bench for bsg_rocc_mem_responder against a
// queue/associative-array reference model.
module tb_bsg_rocc_mem_responder;
  import bsg_rocc_mem_pkg::*;

  localparam int ELS = 256;
  localparam int LAT = 3;
  localparam int PW  = $clog2(LAT+1);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bsg_rocc_mem_responder_if bus();
  logic [PW-1:0] pending;
  logic          err;

  bsg_rocc_mem_responder #(.els_p(ELS), .lat_p(LAT)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .mem_if    (bus),
    .pending_o (pending),
    .err_r_o   (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int             due;
    rocc_mem_resp_s r;
  } exp_t;

  exp_t         q[$];
  logic [63:0]  mm [int];
  bit           err_m = 0;
  int           cyc = 0;
  bit           last_rst = 0;
  logic [7:0]   m_lfsr = 8'h01;
  bit           mon_en = 0;
  int           n_resp = 0;
  int           pend_max = 0;
  logic [63:0]  last_data = '0;
  exp_t         mon_e;
  logic         exp_ready;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    last_rst <= reset_n;
    if (!reset_n) m_lfsr <= 8'h01;
    else          m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  function automatic void model_accept(input rocc_mem_req_s r);
    exp_t e;
    logic [39:0] w;
    bit t64, t32, ld, st, bad;
    logic [63:0] word;
    int k;
    w   = r.req_addr >> 3;
    t64 = (r.req_typ == eRoCC_mem_64bits);
    t32 = (r.req_typ == eRoCC_mem_32bits);
    ld  = (r.req_cmd == eRoCC_mem_load);
    st  = (r.req_cmd == eRoCC_mem_store);
    bad = (w >= 40'(ELS)) || !(ld || st) || !(t64 || t32)
          || (t64 && r.req_addr[2:0] != 0) || (t32 && r.req_addr[1:0] != 0);
    e.due = cyc + LAT - 1;
    e.r = '0;
    e.r.resp_addr     = r.req_addr;
    e.r.resp_tag      = r.req_tag;
    e.r.resp_cmd      = r.req_cmd;
    e.r.resp_typ      = r.req_typ;
    e.r.resp_has_data = ld;
    if (!bad) begin
      k = int'(w);
      word = mm.exists(k) ? mm[k] : 64'hx;
      if (ld) e.r.resp_data = t64 ? word : {32'h0, (r.req_addr[2] ? word[63:32] : word[31:0])};
      if (st) begin
        if (t64)               mm[k] = r.req_data;
        else if (r.req_addr[2]) mm[k] = {r.req_data[31:0], word[31:0]};
        else                   mm[k] = {word[63:32], r.req_data[31:0]};
      end
    end else begin
      err_m = 1;
    end
    q.push_back(e);
  endfunction

  // ---------------- monitor (opposite edge) ----------------
  always @(negedge clk) begin
    if (mon_en) begin
`ifdef BSG_ROCC_MEM_RESPONDER_STALL_EN
      exp_ready = last_rst & ~(m_lfsr[1] & m_lfsr[0]);
`else
      exp_ready = last_rst;
`endif
      check_eq("ready", 64'(bus.mem_req_ready_o), 64'(exp_ready));
      check_eq("pending", 64'(pending), 64'(q.size()));
      check_eq("err", 64'(err), 64'(err_m));
      if (int'(pending) > pend_max) pend_max = int'(pending);
      if (!last_rst) begin
        check_eq("rst_resp_valid", 64'(bus.mem_resp_valid_o), 64'(0));
        check_eq("rst_resp_payload", 64'(|bus.mem_resp_s_o), 64'(0));
      end
      if (bus.mem_resp_valid_o) begin
        n_resp++;
        if (q.size() == 0) begin
          check_eq("spurious_resp_valid", 64'(bus.mem_resp_valid_o), 64'(0));
        end else begin
          mon_e = q.pop_front();
          check_eq("resp_cycle", 64'(cyc), 64'(mon_e.due));
          check_eq("resp_tag", 64'(bus.mem_resp_s_o.resp_tag), 64'(mon_e.r.resp_tag));
          check_eq("resp_addr", 64'(bus.mem_resp_s_o.resp_addr), 64'(mon_e.r.resp_addr));
          check_eq("resp_cmd", 64'(bus.mem_resp_s_o.resp_cmd), 64'(mon_e.r.resp_cmd));
          check_eq("resp_typ", 64'(bus.mem_resp_s_o.resp_typ), 64'(mon_e.r.resp_typ));
          check_eq("resp_has_data", 64'(bus.mem_resp_s_o.resp_has_data), 64'(mon_e.r.resp_has_data));
          check_eq("resp_data", bus.mem_resp_s_o.resp_data, mon_e.r.resp_data);
          last_data = bus.mem_resp_s_o.resp_data;
        end
      end else if (q.size() != 0 && q[0].due <= cyc) begin
        check_eq("resp_valid_missing", 64'(bus.mem_resp_valid_o), 64'(1));
        void'(q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] cmd, input logic [2:0] typ, input logic [39:0] addr,
                      input logic [63:0] data, input logic [9:0] tag);
    rocc_mem_req_s r;
    bit rdy;
    int n;
    r.req_addr = addr;
    r.req_tag  = tag;
    r.req_cmd  = cmd;
    r.req_typ  = typ;
    r.req_phys = 1'($urandom);
    r.req_data = data;
    bus.mem_req_valid_i = 1'b1;
    bus.mem_req_s_i     = r;
    n = 0;
    do begin
      rdy = bus.mem_req_ready_o;
      tick();
      n++;
    end while (!rdy && n < 200);
    if (rdy) model_accept(r);
    else     check_eq("accept_timeout", 64'(rdy), 64'(1));
  endtask

  task automatic idle(input int n);
    bus.mem_req_valid_i = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain();
    int n;
    bus.mem_req_valid_i = 1'b0;
    n = 0;
    while (q.size() != 0 && n < LAT + 10) begin
      tick();
      n++;
    end
    check_eq("drain", 64'(q.size()), 64'(0));
  endtask

  task automatic do_reset(input int n);
    bus.mem_req_valid_i = 1'b0;
    reset_n = 1'b0;
    repeat (n) begin
      tick();
      q.delete();
      err_m = 0;
    end
    reset_n = 1'b1;
    tick();
  endtask

  localparam logic [4:0] LD  = eRoCC_mem_load;
  localparam logic [4:0] ST  = eRoCC_mem_store;
  localparam logic [2:0] T32 = eRoCC_mem_32bits;
  localparam logic [2:0] T64 = eRoCC_mem_64bits;

  initial begin
    int n0;
    logic [4:0]  cmd;
    logic [2:0]  typ;
    logic [39:0] addr;
    int k;

    bus.mem_req_valid_i = 1'b0;
    bus.mem_req_s_i     = '0;
    tick();
    mon_en = 1;
    tick();
    check_eq("ready_in_reset", 64'(bus.mem_req_ready_o), 64'(0));
    check_eq("pending_in_reset", 64'(pending), 64'(0));
    check_eq("err_in_reset", 64'(err), 64'(0));
    reset_n = 1'b1;
    tick();
    check_eq("ready_after_reset", 64'(bus.mem_req_ready_o), 64'(1));

    // 64-bit store then load of the same word
    send(ST, T64, 40'h40, 64'hDEADBEEF_CAFEF00D, 10'd5);
    send(LD, T64, 40'h40, 64'h0, 10'd6);
    drain();
    check_eq("t64_load_data", last_data, 64'hDEADBEEF_CAFEF00D);

    // 32-bit store into the high half, then 64- and 32-bit loads
    send(ST, T32, 40'h44, 64'h11223344, 10'd7);
    send(LD, T64, 40'h40, 64'h0, 10'd8);
    drain();
    check_eq("t32_store_word", last_data, 64'h11223344_CAFEF00D);
    send(LD, T32, 40'h40, 64'h0, 10'd9);
    drain();
    check_eq("t32_load_low", last_data, 64'h00000000_CAFEF00D);

    // back-to-back loads
    pend_max = 0;
    n0 = n_resp;
    for (int i = 0; i < 8; i++) send(LD, (i % 2 == 0) ? T64 : T32, 40'h40 + 40'(4 * (i % 2)), 64'h0, 10'(20 + i));
    drain();
    check_eq("b2b_count", 64'(n_resp - n0), 64'(8));
`ifndef BSG_ROCC_MEM_RESPONDER_STALL_EN
    check_eq("b2b_pending_peak", 64'(pend_max), 64'(LAT));
`endif

    // reset one cycle after an accepted load discards it
    send(LD, T64, 40'h40, 64'h0, 10'd40);
    bus.mem_req_valid_i = 1'b0;
    reset_n = 1'b0;
    tick();
    q.delete();
    err_m = 0;
    check_eq("rst_inflight_ready", 64'(bus.mem_req_ready_o), 64'(0));
    check_eq("rst_inflight_pending", 64'(pending), 64'(0));
    reset_n = 1'b1;
    tick();
    check_eq("rst_release_ready", 64'(bus.mem_req_ready_o), 64'(1));
    idle(LAT + 2);

    // error cases
    check_eq("err_clear", 64'(err), 64'(0));
    send(ST, T32, 40'h42, 64'hAAAA5555, 10'd11);
    bus.mem_req_valid_i = 1'b0;
    check_eq("err_set", 64'(err), 64'(1));
    send(LD, T64, 40'h40, 64'h0, 10'd12);
    drain();
    check_eq("misaligned_unchanged", last_data, 64'h11223344_CAFEF00D);
    send(LD, T64, 40'h800, 64'h0, 10'd13);
    drain();
    check_eq("range_load_zero", last_data, 64'h0);
    check_eq("err_held", 64'(err), 64'(1));

    // randomized traffic over a small initialized window
    for (int i = 0; i < 16; i++) send(ST, T64, 40'(i * 8), {$urandom, $urandom}, 10'(i));
    for (int i = 0; i < 300; i++) begin
      k   = $urandom_range(0, 19);
      typ = $urandom_range(0, 1) ? T64 : T32;
      cmd = $urandom_range(0, 1) ? ST : LD;
      if (k == 0) typ = 3'($urandom_range(0, 7));
      if (k == 1) cmd = 5'($urandom_range(2, 31));
      addr = 40'($urandom_range(0, 15) * 8);
      if (typ == T32) addr = addr + 40'(4 * $urandom_range(0, 1));
      if (k == 2) addr = addr + 40'($urandom_range(1, 3));
      if (k == 3) addr = 40'(ELS * 8) + 40'($urandom_range(0, 1000) * 8);
      send(cmd, typ, addr, {$urandom, $urandom}, 10'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();

    // reset clears the sticky flag
    do_reset(2);
    check_eq("err_after_reset", 64'(err), 64'(0));

    // continuous store stream; every store acknowledged exactly once
    n0 = n_resp;
    for (int i = 0; i < 100; i++) send(ST, T64, 40'($urandom_range(0, 15) * 8), {$urandom, $urandom}, 10'(i));
    drain();
    check_eq("burst_acks", 64'(n_resp - n0), 64'(100));
    for (int i = 0; i < 16; i++) send(LD, T64, 40'(i * 8), 64'h0, 10'(200 + i));
    drain();

    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/bsg_rocc_mem_responder.md
# bsg_rocc_mem_responder

Rocket-side memory responder for the RoCC memory port: accepts `rocc_mem_req_s` requests (loads and stores, 32/64-bit) and returns exactly one `rocc_mem_resp_s` per accepted request after a fixed pipeline latency. It serves as the memory end of the manycore-to-RoCC path in standalone testbenches and FPGA builds that have no Rocket L1. Responses double as credit returns for the requester's outstanding-request counter, so stores are acknowledged too.

## Interface
- `els_p`, 256, number of 64-bit words; power of two, ≥2.
- `lat_p`, 2, accept-to-response latency in cycles; ≥1.
- `clk_i` in 1: the block's single clock.
- `reset_n_i` in 1: reset, synchronous and active-low.
- `mem_req_valid_i` in 1: request valid.
- `mem_req_s_i` in `rocc_mem_req_s`: fields `req_addr`, `req_tag`, `req_cmd`, `req_typ`, `req_phys`, `req_data`.
- `mem_req_ready_o` out 1: request accepted when valid&ready.
- `mem_resp_valid_o` out 1: one-cycle response strobe; not flow-controlled.
- `mem_resp_s_o` out `rocc_mem_resp_s`: fields `resp_addr`, `resp_tag`, `resp_cmd`, `resp_typ`, `resp_data`, `resp_has_data`.
- `pending_o` out `$clog2(lat_p+1)`: responses currently in flight.
- `err_r_o` out 1: sticky error flag.

## Operation
- Accept = `mem_req_valid_i & mem_req_ready_o`; at most one request per cycle.
- Word index = `req_addr[3 +: $clog2(els_p)]`; range error if `req_addr >> 3 ≥ els_p`.
- Alignment error: `eRoCC_mem_32bits` with `req_addr[1:0]≠0`, or `eRoCC_mem_64bits` with `req_addr[2:0]≠0`. Any other `req_typ` is an error.
- Store (`eRoCC_mem_store`): written at the accept edge. 64-bit writes the full word. 32-bit writes half `req_addr[2]` (0=low, 1=high) with `req_data[31:0]`, and the other half is untouched. Response has `resp_has_data=0` and `resp_data=0`.
- Load (`eRoCC_mem_load`): array read at accept, before that edge's write (none in the same cycle). 64-bit returns the word. 32-bit returns the addressed half, zero-extended. `resp_has_data=1`.
- Error cases: store dropped; load returns 0. A response is still issued. `err_r_o` is set and held until reset.
- `req_cmd` other than load/store: treated as an error and answered with `resp_has_data=0`.
- Response echoes `req_addr`, `req_tag`, `req_cmd`, `req_typ` of its request.
- `req_phys` is ignored.
- Responses emerge in accept order.
- `pending_o` increments on accept and decrements on response. On the same cycle it is unchanged.
- Memory contents are not reset.

## Timing
- Request accepted at edge N → `mem_resp_valid_o`=1 during cycle N+`lat_p` for exactly one cycle. Implemented as a `lat_p`-stage valid/payload shift pipeline.
- Back-to-back accepts give back-to-back responses; throughput is 1 per cycle.
- Read-after-write: a store accepted at edge N followed by a load accepted at N+1 to the same address returns the new data.
- Reset (`reset_n_i`=0 sampled at an edge):
  - all pipeline valids are cleared and in-flight responses are discarded, never emitted;
  - `mem_resp_valid_o`=0, `mem_resp_s_o`='0, `pending_o`=0, `err_r_o`=0, `mem_req_ready_o`=0.
- `mem_req_ready_o` rises the cycle after reset deasserts.
- `mem_req_ready_o` is independent of `mem_req_valid_i`, so there is no combinational valid→ready path.

## Configuration
- `BSG_ROCC_MEM_RESPONDER_STALL_EN` defined:
  - an 8-bit Fibonacci LFSR (taps 8,6,5,4; seeded 8'h01 at reset; advances every non-reset cycle) throttles requests;
  - `mem_req_ready_o = ~(lfsr[1] & lfsr[0])`, which exercises requester backpressure.
- Macro undefined: `mem_req_ready_o`=1 in every cycle after reset, and no LFSR logic exists.

## Test plan
- 64-bit store 64'hDEADBEEF_CAFEF00D to addr 0x40, tag 5, then a 64-bit load of 0x40 with tag 6 → two responses at accept+`lat_p`:
  - store response: tag 5, `has_data`=0;
  - load response: tag 6, data 64'hDEADBEEF_CAFEF00D.
- 32-bit store 32'h11223344 to 0x44 over that word → 64-bit load of 0x40 returns 64'h11223344_CAFEF00D; 32-bit load of 0x40 returns 64'h00000000_CAFEF00D.
- `lat_p`=3, 8 loads accepted on consecutive cycles → 8 consecutive response cycles in order, with `pending_o` peaking at 3.
- Misaligned 32-bit store to 0x42 → response issued, memory unchanged, and `err_r_o`=1 from the next cycle until reset. A load to 0x800 with `els_p`=256 returns 0.
- Reset asserted one cycle after a load is accepted (`lat_p`=2) → no response appears, `pending_o`=0, and `mem_req_ready_o` is 0 during reset and 1 the first cycle after.
- With `BSG_ROCC_MEM_RESPONDER_STALL_EN`, 100 stores presented continuously → ready follows the LFSR pattern, all 100 are acknowledged, and no request is lost or duplicated.
